pip_elastic_pipe: RTL and testbench

//   Parametrised elastic pipeline: a chain of DEPTH full-throughput skid slices carrying a

---
 rtl/pip_pkg.sv | 23 ++
 rtl/pip_elastic_pipe_if.sv | 36 +++
 rtl/pip_skid_slice.sv | 63 ++++++
 rtl/pip_elastic_pipe.sv | 64 ++++++
 tb/tb_pip_elastic_pipe.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/pip_pkg.sv
// rtl/pip_pkg.sv - shared constants and helpers for the elastic pipeline
// Purpose: default payload width/depth and a constant-foldable ceil(log2) used
//          to size the occupancy counter.
// Ports:   none (package)
package pip_pkg;

    localparam int PIP_DEF_WIDTH = 8;
    localparam int PIP_DEF_DEPTH = 2;

    // ceil(log2(value)); value <= 1 yields 0.
    function automatic int pip_clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pip_elastic_pipe_if.sv
// rtl/pip_elastic_pipe_if.sv - upstream/downstream handshake bundle of the elastic pipe
// Purpose: groups the valid/ready/data signals of both pipe ends.
// Ports:   master drives in_valid/in_data/out_ready (producer + consumer side),
//          slave is the pipe itself and drives in_ready/out_valid/out_data.
interface pip_elastic_pipe_if
    import pip_pkg::*;
#(
    parameter int WIDTH = PIP_DEF_WIDTH
);

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/pip_skid_slice.sv
// rtl/pip_skid_slice.sv - one full-throughput skid slice (main + skid register)
// Purpose: registered valid/ready stage; up_ready depends only on local state so
//          backpressure travels back one slice per cycle.
// Ports:   clk, srst (sync, active-high), flush (sync kill),
//          up_valid/up_data/up_ready (upstream side),
//          dn_valid/dn_data/dn_ready (downstream side, registered outputs).
module pip_skid_slice
    import pip_pkg::*;
#(
    parameter int WIDTH = PIP_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             up_ready,
    output logic             dn_valid,
    output logic [WIDTH-1:0] dn_data,
    input  logic             dn_ready
);

    logic             m_v;
    logic [WIDTH-1:0] m_d;
    logic             s_v;
    logic [WIDTH-1:0] s_d;
    logic             up_xfer;
    logic             dn_xfer;

    assign up_ready = !s_v;
    assign dn_valid = m_v;
    assign dn_data  = m_d;
    assign up_xfer  = up_valid & !s_v;
    assign dn_xfer  = m_v & dn_ready;

    // Skid is only ever occupied while main is, so the head is always main.
    always_ff @(posedge clk) begin
        if (srst || flush) begin
            m_v <= 1'b0;
            m_d <= '0;
            s_v <= 1'b0;
            s_d <= '0;
        end else if (dn_xfer) begin
            if (s_v) begin
                m_d <= s_d;
                s_v <= 1'b0;
            end else if (up_xfer) begin
                m_d <= up_data;
            end else begin
                m_v <= 1'b0;
            end
        end else if (up_xfer) begin
            if (m_v) begin
                s_d <= up_data;
                s_v <= 1'b1;
            end else begin
                m_d <= up_data;
                m_v <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pip_elastic_pipe.sv
// rtl/pip_elastic_pipe.sv - DEPTH-slice elastic pipeline with flush and occupancy
// Purpose: chain of skid slices (latency DEPTH, capacity 2*DEPTH, 1 word/cycle).
// Ports:   clk, srst (sync, active-high), flush (sync kill of in-flight words),
//          pipe (slave handshake bundle: in_* upstream, out_* downstream),
//          occupancy (registered count of held entries, 0..2*DEPTH).
module pip_elastic_pipe
    import pip_pkg::*;
#(
    parameter  int WIDTH = PIP_DEF_WIDTH,
    parameter  int DEPTH = PIP_DEF_DEPTH,
    localparam int CNT_W = pip_clog2(2*DEPTH+1)
) (
    input  logic                clk,
    input  logic                srst,
    input  logic                flush,
    pip_elastic_pipe_if.slave   pipe,
    output logic [CNT_W-1:0]    occupancy
);

    // link k is the upstream side of slice k; link DEPTH is the pipe output.
    logic             link_valid [DEPTH+1];
    logic [WIDTH-1:0] link_data  [DEPTH+1];
    logic             link_ready [DEPTH+1];
    logic             in_xfer;
    logic             out_xfer;

    assign link_valid[0]     = pipe.in_valid;
    assign link_data[0]      = pipe.in_data;
    assign link_ready[DEPTH] = pipe.out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_slice
        pip_skid_slice #(.WIDTH(WIDTH)) u_slice (
            .clk      (clk),
            .srst     (srst),
            .flush    (flush),
            .up_valid (link_valid[k]),
            .up_data  (link_data[k]),
            .up_ready (link_ready[k]),
            .dn_valid (link_valid[k+1]),
            .dn_data  (link_data[k+1]),
            .dn_ready (link_ready[k+1])
        );
    end

    // Flush is the only combinational term on in_ready: nothing is accepted
    // in the cycle whose contents are about to be discarded.
    assign pipe.in_ready  = link_ready[0] & !flush;
    assign pipe.out_valid = link_valid[DEPTH];
    assign pipe.out_data  = link_data[DEPTH];

    assign in_xfer  = pipe.in_valid & pipe.in_ready;
    assign out_xfer = pipe.out_valid & pipe.out_ready;

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            occupancy <= '0;
        end else if (in_xfer && !out_xfer) begin
            occupancy <= occupancy + CNT_W'(1);
        end else if (!in_xfer && out_xfer) begin
            occupancy <= occupancy - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pip_elastic_pipe.sv
// tb/tb_pip_elastic_pipe.sv - self-checking bench for pip_elastic_pipe
module tb_pip_elastic_pipe;
    import pip_pkg::*;

    localparam int OW2 = pip_clog2(2*PIP_DEF_DEPTH+1);
    localparam int OW1 = pip_clog2(3);
    localparam int OW3 = pip_clog2(7);

    logic clk;
    logic srst;
    logic flush;
    logic [OW2-1:0] occ2;
    logic [OW1-1:0] occ1;
    logic [OW3-1:0] occ3;

    pip_elastic_pipe_if #(.WIDTH(PIP_DEF_WIDTH)) if2 ();
    pip_elastic_pipe_if #(.WIDTH(13))            if1 ();
    pip_elastic_pipe_if #(.WIDTH(13))            if3 ();

    pip_elastic_pipe #(.WIDTH(PIP_DEF_WIDTH), .DEPTH(PIP_DEF_DEPTH)) u_d2 (
        .clk(clk), .srst(srst), .flush(flush), .pipe(if2), .occupancy(occ2));
    pip_elastic_pipe #(.WIDTH(13), .DEPTH(1)) u_d1 (
        .clk(clk), .srst(srst), .flush(flush), .pipe(if1), .occupancy(occ1));
    pip_elastic_pipe #(.WIDTH(13), .DEPTH(3)) u_d3 (
        .clk(clk), .srst(srst), .flush(flush), .pipe(if3), .occupancy(occ3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // random-test drive/observe arrays: index 0 -> DEPTH=1, index 1 -> DEPTH=3
    logic        r_iv [2];
    logic [12:0] r_id [2];
    logic        r_or [2];
    logic        r_ov [2];
    logic        r_ir [2];
    logic [12:0] r_od [2];
    int          r_occ[2];

    assign if1.in_valid  = r_iv[0];
    assign if1.in_data   = r_id[0];
    assign if1.out_ready = r_or[0];
    assign if3.in_valid  = r_iv[1];
    assign if3.in_data   = r_id[1];
    assign if3.out_ready = r_or[1];

    always_comb begin
        r_ov[0]  = if1.out_valid;
        r_ir[0]  = if1.in_ready;
        r_od[0]  = if1.out_data;
        r_occ[0] = int'(occ1);
        r_ov[1]  = if3.out_valid;
        r_ir[1]  = if3.in_ready;
        r_od[1]  = if3.out_data;
        r_occ[1] = int'(occ3);
    end

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       fl;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        int         e_occ;
    } vec_t;

    vec_t tbl [22];

    logic [12:0] q1 [$];
    logic [12:0] q3 [$];

    initial begin
        logic        held_ov [2];
        logic [12:0] held_od [2];
        logic        in_stall [2];
        logic [12:0] head;
        int          sz;
        int          exp_occ;

        // iv  data  ordy fl | in_ready out_valid out_data occupancy
        tbl[0]  = '{1'b1, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0};
        tbl[1]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1};
        tbl[2]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 2};
        tbl[3]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 3};
        tbl[4]  = '{1'b1, 8'hA4, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 4};
        tbl[5]  = '{1'b1, 8'hA4, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA0, 4};
        tbl[6]  = '{1'b1, 8'hA4, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 3};
        tbl[7]  = '{1'b1, 8'hA4, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA2, 2};
        tbl[8]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA3, 2};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA4, 2};
        tbl[10] = '{1'b1, 8'hB0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA4, 2};
        tbl[11] = '{1'b1, 8'hB1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA4, 3};
        tbl[12] = '{1'b1, 8'hC0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0};
        tbl[13] = '{1'b1, 8'hC1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1};
        tbl[14] = '{1'b1, 8'hC2, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC0, 2};
        tbl[15] = '{1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC0, 3};
        tbl[16] = '{1'b1, 8'hC4, 1'b0, 1'b1, 1'b0, 1'b1, 8'hC0, 4};
        tbl[17] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0};
        tbl[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1};
        tbl[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 1};
        tbl[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55, 1};
        tbl[21] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55, 0};

        for (int k = 0; k < 2; k++) begin
            r_iv[k] = 1'b0; r_id[k] = '0; r_or[k] = 1'b0;
            held_ov[k] = 1'b0; held_od[k] = '0; in_stall[k] = 1'b0;
        end

        // reset held two cycles with in_valid asserted
        srst = 1'b1; flush = 1'b0;
        if2.in_valid = 1'b1; if2.in_data = 8'h77; if2.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        srst = 1'b0; if2.in_valid = 1'b0;
        #1;
        chk("reset out_valid", 32'(if2.out_valid), 32'd0);
        chk("reset out_data", 32'(if2.out_data), 32'd0);
        chk("reset occupancy", 32'(occ2), 32'd0);
        chk("reset in_ready", 32'(if2.in_ready), 32'd1);

        // backpressure, flush+out transfer, flush while full, post-flush latency
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if2.in_valid = tbl[i].iv; if2.in_data = tbl[i].d;
            if2.out_ready = tbl[i].ordy; flush = tbl[i].fl;
            #1;
            chk($sformatf("row%0d in_ready", i), 32'(if2.in_ready), 32'(tbl[i].e_ir));
            chk($sformatf("row%0d out_valid", i), 32'(if2.out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("row%0d out_data", i), 32'(if2.out_data), 32'(tbl[i].e_od));
            chk($sformatf("row%0d occupancy", i), 32'(occ2), 32'(tbl[i].e_occ));
        end

        // streaming 0x01..0x10 with downstream always ready
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            flush = 1'b0; if2.out_ready = 1'b1;
            if2.in_valid = (i < 16); if2.in_data = (i < 16) ? 8'(i + 1) : 8'h00;
            #1;
            exp_occ = (i < 2) ? i : ((i <= 16) ? 2 : 1);
            chk($sformatf("stream%0d out_valid", i), 32'(if2.out_valid), 32'(i >= 2));
            if (i >= 2) chk($sformatf("stream%0d out_data", i), 32'(if2.out_data), 32'(i - 1));
            chk($sformatf("stream%0d occupancy", i), 32'(occ2), 32'(exp_occ));
            if (i < 16) chk($sformatf("stream%0d in_ready", i), 32'(if2.in_ready), 32'd1);
        end

        @(negedge clk);
        if2.in_valid = 1'b0; if2.out_ready = 1'b0;
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;

        // random valid/ready on DEPTH=1 and DEPTH=3, WIDTH=13
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                sz   = (k == 0) ? q1.size() : q3.size();
                head = (sz > 0) ? ((k == 0) ? q1[0] : q3[0]) : 13'h0;
                chk($sformatf("rand%0d occupancy", k), 32'(r_occ[k]), 32'(sz));
                if (r_ov[k]) begin
                    chk($sformatf("rand%0d sb_nonempty", k), 32'(sz > 0), 32'd1);
                    chk($sformatf("rand%0d out_data", k), 32'(r_od[k]), 32'(head));
                end
                if (held_ov[k]) begin
                    chk($sformatf("rand%0d stall_valid", k), 32'(r_ov[k]), 32'd1);
                    chk($sformatf("rand%0d stall_data", k), 32'(r_od[k]), 32'(held_od[k]));
                end
                if (!in_stall[k]) begin
                    r_iv[k] = ($urandom_range(0, 3) != 0);
                    r_id[k] = 13'($urandom);
                end
                r_or[k] = ($urandom_range(0, 2) != 0) || (c > 1900);
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                if (r_ov[k] && r_or[k]) begin
                    if (k == 0 && q1.size() > 0) void'(q1.pop_front());
                    if (k == 1 && q3.size() > 0) void'(q3.pop_front());
                end
                if (r_iv[k] && r_ir[k]) begin
                    if (k == 0) q1.push_back(r_id[k]);
                    else q3.push_back(r_id[k]);
                end
                held_ov[k]  = r_ov[k] && !r_or[k];
                held_od[k]  = r_od[k];
                in_stall[k] = r_iv[k] && !r_ir[k];
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
